// File: rtl/ps2_host_tx.sv
// ps2_host_tx: sends one host-to-device PS/2 command byte (inhibit, request-to-send, 11-bit frame, ACK check).
// Latency: INHIBIT_CYCLES+1 cycles to start bit, then paced by the device clock; pin edge reaches the FSM 2+FILTER_LEN cycles later.
// Backpressure: tx_start is taken only in IDLE; pulses while busy (or during reset) are dropped.
//
// Ports:
//   clk, reset                 system clock, synchronous active-high reset
//   tx_data, tx_start          command byte and one-cycle start request
//   ps2_clk_in, ps2_data_in    raw (asynchronous) PS/2 pin levels
//   ps2_clk_oe, ps2_data_oe    open-collector pull-low enables (1 = drive low)
//   busy, done, err            in-progress flag, end-of-transaction pulse, result (00 ok, 01 NACK, 10 timeout)
//
// Optional build macro PS2_TX_RETRY_EN: on NACK/timeout, release the lines, idle INHIBIT_CYCLES and
// resend the same byte, up to 2 retries; done/err only report the final outcome.

module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 6000,
   parameter int TIMEOUT_CYCLES = 1000000,
   parameter int FILTER_LEN     = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] tx_data,
   input  logic       tx_start,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   output logic       busy,
   output logic       done,
   output logic [1:0] err
);

   localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
   localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam int FLT_W = $clog2(FILTER_LEN + 1);

   localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILTER_LEN - 1);

   localparam logic [1:0] RES_OK      = 2'b00;
   localparam logic [1:0] RES_NACK    = 2'b01;
   localparam logic [1:0] RES_TIMEOUT = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE,
      S_INHIBIT,
      S_REQ,
      S_SHIFT,
      S_ACK,
      S_WAIT_IDLE,
      S_DONE
`ifdef PS2_TX_RETRY_EN
      , S_RETRY_WAIT
`endif
   } state_t;

   // ------------------------------------------------------------------
   // Pin conditioning: 2-FF synchronizers, then a run-length filter on
   // the clock so a single noisy sample never produces a fall.
   // ------------------------------------------------------------------
   logic             clk_s1, clk_s2;
   logic             data_s1, data_s2;
   logic             clk_f;
   logic             fall;
   logic [FLT_W-1:0] flt_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         clk_s1  <= 1'b1;
         clk_s2  <= 1'b1;
         data_s1 <= 1'b1;
         data_s2 <= 1'b1;
         clk_f   <= 1'b1;
         flt_cnt <= '0;
         fall    <= 1'b0;
      end else begin
         clk_s1  <= ps2_clk_in;
         clk_s2  <= clk_s1;
         data_s1 <= ps2_data_in;
         data_s2 <= data_s1;
         fall    <= 1'b0;
         if (clk_s2 == clk_f) begin
            flt_cnt <= '0;
         end else if (flt_cnt == FLT_LAST) begin
            // FILTER_LEN consecutive differing samples: accept the new level
            clk_f   <= clk_s2;
            flt_cnt <= '0;
            fall    <= ~clk_s2;
         end else begin
            flt_cnt <= flt_cnt + 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Transmit FSM
   // ------------------------------------------------------------------
   state_t           state;
   logic [7:0]       data_q;
   logic             par_q;
   logic [3:0]       bit_cnt;
   logic [INH_W-1:0] inh_cnt;
   logic [TO_W-1:0]  to_cnt;
   logic [1:0]       result;
`ifdef PS2_TX_RETRY_EN
   logic [1:0]       retry_cnt;
`endif

   // End of an attempt: either the device stopped clocking, or the bus
   // returned to idle after the ACK slot.
   logic       fin_vld;
   logic [1:0] fin_res;

   always_comb begin
      fin_vld = 1'b0;
      fin_res = result;
      if ((state inside {S_SHIFT, S_ACK, S_WAIT_IDLE}) && !fall && (to_cnt == TO_LAST)) begin
         fin_vld = 1'b1;
         fin_res = RES_TIMEOUT;
      end else if ((state == S_WAIT_IDLE) && clk_f && data_s2) begin
         fin_vld = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         ps2_clk_oe  <= 1'b0;
         ps2_data_oe <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         err         <= RES_OK;
         result      <= RES_OK;
         data_q      <= '0;
         par_q       <= 1'b0;
         bit_cnt     <= '0;
         inh_cnt     <= '0;
         to_cnt      <= '0;
`ifdef PS2_TX_RETRY_EN
         retry_cnt   <= '0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (tx_start) begin
                  data_q      <= tx_data;
                  par_q       <= ~^tx_data;
                  err         <= RES_OK;
                  busy        <= 1'b1;
                  ps2_clk_oe  <= 1'b1;
                  ps2_data_oe <= 1'b0;
                  inh_cnt     <= '0;
`ifdef PS2_TX_RETRY_EN
                  retry_cnt   <= '0;
`endif
                  state       <= S_INHIBIT;
               end
            end

            S_INHIBIT: begin
               if (inh_cnt == INH_LAST) begin
                  ps2_data_oe <= 1'b1;   // start bit while clock is still held
                  state       <= S_REQ;
               end else begin
                  inh_cnt <= inh_cnt + 1'b1;
               end
            end

            S_REQ: begin
               ps2_clk_oe <= 1'b0;       // hand the clock to the device
               bit_cnt    <= '0;
               to_cnt     <= '0;
               state      <= S_SHIFT;
            end

            S_SHIFT, S_ACK, S_WAIT_IDLE: begin
               if (fall) to_cnt <= '0;
               else      to_cnt <= to_cnt + 1'b1;

               if (state == S_SHIFT) begin
                  // data changes just after a device fall; device samples on the rise
                  if (fall) begin
                     bit_cnt <= bit_cnt + 4'd1;
                     if (bit_cnt < 4'd8) begin
                        ps2_data_oe <= ~data_q[bit_cnt[2:0]];
                     end else if (bit_cnt == 4'd8) begin
                        ps2_data_oe <= ~par_q;
                     end else begin
                        ps2_data_oe <= 1'b0;  // stop bit = released line
                        state       <= S_ACK;
                     end
                  end
               end else if (state == S_ACK) begin
                  if (fall) begin
                     result <= data_s2 ? RES_NACK : RES_OK;
                     state  <= S_WAIT_IDLE;
                  end
               end
            end

            S_DONE: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end

`ifdef PS2_TX_RETRY_EN
            S_RETRY_WAIT: begin
               if (inh_cnt == INH_LAST) begin
                  ps2_clk_oe <= 1'b1;
                  inh_cnt    <= '0;
                  state      <= S_INHIBIT;
               end else begin
                  inh_cnt <= inh_cnt + 1'b1;
               end
            end
`endif

            default: state <= S_IDLE;
         endcase

         // Attempt finished: release both lines and report (or retry).
         if (fin_vld) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
`ifdef PS2_TX_RETRY_EN
            if ((fin_res != RES_OK) && (retry_cnt != 2'd2)) begin
               retry_cnt <= retry_cnt + 1'b1;
               inh_cnt   <= '0;
               state     <= S_RETRY_WAIT;
            end else
`endif
            begin
               done  <= 1'b1;
               err   <= fin_res;
               state <= S_DONE;
            end
         end
      end
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: drives ps2_host_tx against a behavioural PS/2 keyboard model.
// Latency: device clock period 40 cycles; each frame takes roughly 500 cycles.
// Backpressure: commands are issued only after the previous done pulse.
`timescale 1ns/1ps

module tb_ps2_host_tx;

   localparam int INH      = 20;
   localparam int TMO      = 2000;
   localparam int FLT      = 4;
   localparam int HALF_BIT = 20;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic       tx_start = 1'b0;
   logic       ps2_clk_in, ps2_data_in;
   logic       ps2_clk_oe, ps2_data_oe;
   logic       busy, done;
   logic [1:0] err;

   // keyboard side of the open-collector bus
   logic dev_clk_low = 1'b0;
   logic dev_dat_low = 1'b0;
   logic clk_glitch  = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;

   int         done_cnt = 0;
   logic [1:0] done_err = 2'b00;
   logic       busy_at_done = 1'b0;
   logic       busy_after_done = 1'b1;
   logic       done_prev = 1'b0;

   always #5 clk = ~clk;

   assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low) ^ clk_glitch;
   assign ps2_data_in = ~(ps2_data_oe | dev_dat_low);

   ps2_host_tx #(
      .INHIBIT_CYCLES(INH),
      .TIMEOUT_CYCLES(TMO),
      .FILTER_LEN    (FLT)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .tx_data    (tx_data),
      .tx_start   (tx_start),
      .ps2_clk_in (ps2_clk_in),
      .ps2_data_in(ps2_data_in),
      .ps2_clk_oe (ps2_clk_oe),
      .ps2_data_oe(ps2_data_oe),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   // done-pulse monitor
   always @(negedge clk) begin
      if (done_prev) busy_after_done = busy;
      if (done) begin
         done_cnt     = done_cnt + 1;
         done_err     = err;
         busy_at_done = busy;
      end
      done_prev = done;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference frame as the keyboard sees it: bit0 start, bits1..8 data LSB first,
   // bit9 odd parity (total ones incl. parity is odd), bit10 stop.
   function automatic logic [10:0] frame_of(input logic [7:0] d);
      logic par;
      par = (($countones(d) % 2) == 0);
      return {1'b1, par, d, 1'b0};
   endfunction

   // wait n cycles; optionally inject a 1-cycle clock glitch and a stray tx_start
   task automatic hold(input int n, input bit noisy);
      for (int c = 0; c < n; c++) begin
         clk_glitch = noisy && (c == 10);
         if (noisy && c == 5) begin
            tx_start = 1'b1;
            tx_data  = 8'hA5;
         end else begin
            tx_start = 1'b0;
         end
         @(negedge clk);
      end
      clk_glitch = 1'b0;
      tx_start   = 1'b0;
   endtask

   task automatic send_cmd(input logic [7:0] d);
      @(negedge clk);
      tx_data  = d;
      tx_start = 1'b1;
      @(negedge clk);
      tx_start = 1'b0;
   endtask

   task automatic check_request(input string tag);
      int inh;
      int req;
      inh = 0;
      req = 0;
      while (ps2_clk_oe && !ps2_data_oe && inh < 200) begin
         inh++;
         @(negedge clk);
      end
      while (ps2_clk_oe && ps2_data_oe && req < 10) begin
         req++;
         @(negedge clk);
      end
      check({tag, "_inhibit_len"}, inh, INH);
      check({tag, "_req_len"}, req, 1);
      check({tag, "_shift_oe"}, {ps2_clk_oe, ps2_data_oe}, 2'b01);
   endtask

   // Keyboard: clocks 10 bits sampling on each rise, then an ACK slot.
   // stop_after < 11 returns with the clock still held low after that fall.
   task automatic dev_frame(input bit ack, input bit noisy, input int stop_after,
                            output logic [10:0] cap);
      cap    = '0;
      cap[0] = ps2_data_in;
      hold(5, 1'b0);
      for (int i = 1; i <= 10; i++) begin
         dev_clk_low = 1'b1;
         hold(HALF_BIT, noisy);
         cap[i] = ps2_data_in;
         if (i == stop_after) return;
         dev_clk_low = 1'b0;
         hold(HALF_BIT, noisy);
      end
      dev_dat_low = ack;
      hold(5, 1'b0);
      dev_clk_low = 1'b1;
      hold(HALF_BIT, noisy);
      dev_clk_low = 1'b0;
      hold(2, 1'b0);
      dev_dat_low = 1'b0;
   endtask

   task automatic wait_done(input int start, input int budget, input string tag);
      int n;
      n = 0;
      while (done_cnt == start && n < budget) begin
         n++;
         @(negedge clk);
      end
      repeat (3) @(negedge clk);
      check({tag, "_done_count"}, done_cnt - start, 1);
   endtask

   task automatic run_txn(input logic [7:0] d, input bit ack, input bit noisy, input string tag);
      logic [10:0] cap;
      int          start;
      start = done_cnt;
      send_cmd(d);
      check({tag, "_busy"}, busy, 1);
      check_request(tag);
      dev_frame(ack, noisy, 99, cap);
      wait_done(start, 500, tag);
      check({tag, "_frame"}, cap, frame_of(d));
      check({tag, "_err"}, done_err, ack ? 0 : 1);
      check({tag, "_err_held"}, err, ack ? 0 : 1);
      check({tag, "_oe_idle"}, {ps2_clk_oe, ps2_data_oe}, 2'b00);
   endtask

   initial begin
      logic [10:0] cap;
      logic [7:0]  d;
      bit          ack;
      int          start;
      int          n;

      // reset state
      repeat (3) @(negedge clk);
      check("rst_clk_oe", ps2_clk_oe, 0);
      check("rst_data_oe", ps2_data_oe, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      reset = 1'b0;
      repeat (5) @(negedge clk);

      // directed commands
      run_txn(8'hF4, 1'b1, 1'b0, "f4");
      run_txn(8'hED, 1'b1, 1'b0, "ed");
      check("ed_busy_at_done", busy_at_done, 1);
      check("ed_busy_after_done", busy_after_done, 0);

`ifndef PS2_TX_RETRY_EN
      // device leaves data high in the ACK slot
      run_txn(8'hFF, 1'b0, 1'b0, "nack");

      // device never clocks: timeout measured from SHIFT entry
      start = done_cnt;
      send_cmd(8'h55);
      check_request("tmo");
      n = 0;
      while (!done && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("tmo_latency", n, TMO);
      check("tmo_err", err, 2);
      check("tmo_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
      repeat (3) @(negedge clk);
      check("tmo_done_count", done_cnt - start, 1);
`else
      // first attempt NACK, retry ACKed: one done, err ok
      start = done_cnt;
      send_cmd(8'hED);
      check_request("retry1");
      dev_frame(1'b0, 1'b0, 99, cap);
      n = 0;
      while (!ps2_clk_oe && n < 300) begin
         if (!busy) n = 1000;
         @(negedge clk);
         n++;
      end
      check("retry_busy_held", busy, 1);
      check("retry_no_early_done", done_cnt - start, 0);
      check_request("retry2");
      dev_frame(1'b1, 1'b0, 99, cap);
      wait_done(start, 500, "retry");
      check("retry_frame", cap, frame_of(8'hED));
      check("retry_err", done_err, 0);
`endif

      // reset after fall 5, with a coincident tx_start that must be dropped
      start = done_cnt;
      send_cmd(8'h3C);
      check_request("rstmid");
      dev_frame(1'b1, 1'b0, 5, cap);
      check("rstmid_partial_frame", cap[5:0], 6'(frame_of(8'h3C)));
      reset    = 1'b1;
      tx_start = 1'b1;
      tx_data  = 8'h99;
      @(negedge clk);
      check("rstmid_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
      check("rstmid_busy", busy, 0);
      reset       = 1'b0;
      tx_start    = 1'b0;
      dev_clk_low = 1'b0;
      @(negedge clk);
      check("rstmid_start_ignored", busy, 0);
      repeat (100) @(negedge clk);
      check("rstmid_no_done", done_cnt - start, 0);
      run_txn(8'hF4, 1'b1, 1'b0, "after_rst");

      // clock glitches plus stray tx_start while busy
      run_txn(8'h81, 1'b1, 1'b1, "noisy");

      // randomized commands against the frame model
      for (int k = 0; k < 8; k++) begin
         d = 8'($urandom);
`ifdef PS2_TX_RETRY_EN
         ack = 1'b1;
`else
         ack = ($urandom_range(0, 3) != 0);
`endif
         run_txn(d, ack, k[0], $sformatf("rnd%0d", k));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. It is the send side of the keyboard link, paired with the existing PS/2 scan-code receiver.
- Sends one command byte to the keyboard (e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset) using open-collector clock/data pin drives.
- It inhibits the bus, issues request-to-send, shifts data on device-generated clock edges, then checks the device ACK.
- Sits beside the receiver on the CLOCK_50 domain. `busy` lets the top level ignore receiver output during a transmission.

Parameters:
INHIBIT_CYCLES, 6000, clk cycles ps2_clk is held low before request-to-send (120 us at 50 MHz)
TIMEOUT_CYCLES, 1000000, max clk cycles between expected device clock falling edges (20 ms)
FILTER_LEN, 8, consecutive equal samples required before the filtered ps2_clk changes

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
tx_data  input  8  command byte; sampled when tx_start is accepted
tx_start  input  1  one-cycle request; accepted only in IDLE
ps2_clk_in  input  1  raw PS/2 clock pin level (asynchronous)
ps2_data_in  input  1  raw PS/2 data pin level (asynchronous)
ps2_clk_oe  output  1  1 = drive PS2_CLK low, 0 = release
ps2_data_oe  output  1  1 = drive PS2_DAT low, 0 = release
busy  output  1  high from the cycle after accept until done
done  output  1  one-cycle pulse at end of transaction
err  output  2  valid with done: 00 ok, 01 NACK, 10 timeout; held until next accept

Behaviour:
- Reset values: ps2_clk_oe=0, ps2_data_oe=0, busy=0, done=0, err=00, state IDLE, all counters 0.
- Reset mid-operation: both oe released on the next edge, and no done pulse is produced.
- Input conditioning: ps2_clk_in and ps2_data_in each pass through a 2-FF synchronizer.
- Clock filter: filtered clk updates only after FILTER_LEN identical synced samples.
- fall = one-cycle pulse on filtered clk 1->0. Latency from the pin edge to fall is 2+FILTER_LEN cycles.
- IDLE: oe=00, busy=0.
  - On tx_start: latch tx_data and compute par = ~^tx_data (odd parity).
  - Clear err and go to INHIBIT.
  - tx_start in any other state, or coincident with reset, is ignored.
- INHIBIT: clk_oe=1, data_oe=0 for exactly INHIBIT_CYCLES cycles -> REQ.
- REQ: clk_oe=1, data_oe=1 (start bit 0) for exactly 1 cycle -> SHIFT, with bit_cnt=0 and timeout counter cleared.
- SHIFT: clk_oe=0. On each fall, bit_cnt increments and data_oe is set to the inverse of the next frame bit:
  - falls 1..8 present tx_data[0..7], LSB first;
  - fall 9 presents par;
  - fall 10 presents the stop bit (data_oe=0, released) -> ACK.
- ACK: on the next fall, sample synced data.
  - Data 0 -> result ok; data 1 -> result NACK.
  - Go to WAIT_IDLE.
- WAIT_IDLE: wait until filtered clk=1 and synced data=1 -> DONE.
- DONE: done=1 for one cycle, err=result, busy=0 in the following cycle -> IDLE.
- Timeout:
  - The counter runs in SHIFT, ACK and WAIT_IDLE and clears on every fall.
  - When it reaches TIMEOUT_CYCLES: oe=00 next cycle, result=timeout -> DONE.
- data_oe changes only in the cycle after a fall (device samples on the rising edge).
- No glitch on oe outputs: both are registered.

Optional Feature:
PS2_TX_RETRY_EN
- Defined: on a NACK or timeout result, the block releases the lines, waits INHIBIT_CYCLES idle, then re-enters INHIBIT with the same latched byte.
  - Up to 2 retries.
  - busy stays high throughout.
  - done/err are reported only after success or after the final failed attempt.
- Undefined: a single attempt; the result is reported directly.

Test Plan (bench: INHIBIT_CYCLES=20, TIMEOUT_CYCLES=2000, FILTER_LEN=4; device model clocks at 40-cycle period):
- tx_start with 0xF4 -> clk_oe high for 20 cycles with data_oe=0, then 1 cycle with both=1; device captures 0,0,0,1,0,1,1,1,1 then parity 0, stop 1; model ACKs low -> done with err=00.
- tx_start with 0xED -> device captures LSB-first 1,0,1,1,0,1,1,1, parity 1; ACK -> err=00; busy falls the cycle after done.
- 0xFF with model leaving data high at the ACK slot -> err=01, both oe=0 (macro off).
- Device never clocks after REQ -> done at 2000 cycles after entering SHIFT, err=10, oe=00.
- reset asserted after fall 5 -> oe=00 and busy=0 next cycle, no done; a subsequent tx_start 0xF4 completes with err=00.
- tx_start pulsed while busy, and 1-cycle glitches on ps2_clk_in -> ignored; frame bits unchanged.
  - With PS2_TX_RETRY_EN: first attempt NACK, second ACK -> exactly one done, err=00.
